mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_pick2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states and requester ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } arb_state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker: bit 0 of elig/req is the core, bit 1 the host.
module arb_pick2
    import mem_arb_pkg::*;
#(
    parameter int HOST_PRIO = 0
) (
    input  logic [1:0] elig,
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

    logic [1:0] cand_s;

    // Pick among eligible requesters; a conflict follows the priority policy.
    always_comb begin
        cand_s = elig & req;
        valid  = |cand_s;
        winner = REQ_CORE;
        case (cand_s)
            2'b01:   winner = REQ_CORE;
            2'b10:   winner = REQ_HOST;
            2'b11:   winner = (HOST_PRIO != 0) ? REQ_HOST : ~last_grant;
            default: winner = REQ_CORE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-beat memory port between the core and the host loader,
// with round-robin or host-priority arbitration and an optional bus lock.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int HOST_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              c_lock,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              winner_q, winner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              lock_owner_valid_q, lock_owner_valid_d;
    logic              lock_owner_q, lock_owner_d;
    logic              last_grant_q, last_grant_d;

    logic [1:0]        elig_s;
    logic              pick_winner_s;
    logic              pick_valid_s;
    logic              win_lock_s;

    // While a lock is held only its owner may be considered.
    always_comb begin
        if (lock_owner_valid_q) begin
            elig_s = (lock_owner_q == REQ_HOST) ? 2'b10 : 2'b01;
        end else begin
            elig_s = 2'b11;
        end
    end

    arb_pick2 #(
        .HOST_PRIO (HOST_PRIO)
    ) u_pick (
        .elig       (elig_s),
        .req        ({h_req, c_req}),
        .last_grant (last_grant_q),
        .winner     (pick_winner_s),
        .valid      (pick_valid_s)
    );

    // Next-state logic: latch the winning transaction and update lock/fairness.
    always_comb begin
        state_d            = state_q;
        winner_d           = winner_q;
        we_d               = we_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        lock_owner_valid_d = lock_owner_valid_q;
        lock_owner_d       = lock_owner_q;
        last_grant_d       = last_grant_q;
        win_lock_s         = (pick_winner_s == REQ_HOST) ? h_lock : c_lock;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    winner_d     = pick_winner_s;
                    we_d         = (pick_winner_s == REQ_HOST) ? h_we    : c_we;
                    addr_d       = (pick_winner_s == REQ_HOST) ? h_addr  : c_addr;
                    wdata_d      = (pick_winner_s == REQ_HOST) ? h_wdata : c_wdata;
                    last_grant_d = pick_winner_s;
                    state_d      = ACCESS;
                    if (win_lock_s) begin
                        lock_owner_valid_d = 1'b1;
                        lock_owner_d       = pick_winner_s;
                    end else if (lock_owner_valid_q && (lock_owner_q == pick_winner_s)) begin
                        lock_owner_valid_d = 1'b0;
                    end else begin
                        lock_owner_valid_d = lock_owner_valid_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RDATA;
            end
            RDATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= IDLE;
            winner_q           <= REQ_CORE;
            we_q               <= 1'b0;
            addr_q             <= {ADDR_W{1'b0}};
            wdata_q            <= {DATA_W{1'b0}};
            lock_owner_valid_q <= 1'b0;
            lock_owner_q       <= REQ_CORE;
            last_grant_q       <= REQ_HOST;
        end else begin
            state_q            <= state_d;
            winner_q           <= winner_d;
            we_q               <= we_d;
            addr_q             <= addr_d;
            wdata_q            <= wdata_d;
            lock_owner_valid_q <= lock_owner_valid_d;
            lock_owner_q       <= lock_owner_d;
            last_grant_q       <= last_grant_d;
        end
    end

    // Output decode from state; read data passes straight through in RDATA.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_we    = 1'b0;
        c_gnt     = 1'b0;
        h_gnt     = 1'b0;
        c_rvalid  = 1'b0;
        h_rvalid  = 1'b0;
        c_rdata   = {DATA_W{1'b0}};
        h_rdata   = {DATA_W{1'b0}};
        busy      = (state_q != IDLE);
        case (state_q)
            ACCESS: begin
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_wdata = wdata_q;
                c_gnt     = (winner_q == REQ_CORE);
                h_gnt     = (winner_q == REQ_HOST);
            end
            RDATA: begin
                mem_addr = addr_q;
                if (winner_q == REQ_HOST) begin
                    h_rvalid = 1'b1;
                    h_rdata  = mem_rdata;
                end else begin
                    c_rvalid = 1'b1;
                    c_rdata  = mem_rdata;
                end
            end
            IDLE: begin
                busy = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
